master_slave_sections_rr: RTL

//  Parametrised multi-channel master/slave section block. It samples NUM_CH non-blocking

---
 rtl/master_slave_sections_rr.sv | 102 ++++++++++
 1 files changed

// File: rtl/master_slave_sections_rr.sv
// Multi-channel master/slave section block: round-robin grant of synced slave inputs in
// SECTION_A, publication of the latched/accumulated value on the master output in SECTION_B.
module master_slave_sections_rr #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned RESET_VAL = 1337,
  parameter int unsigned MODE      = 0,
  localparam int unsigned CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*WIDTH-1:0]  s_in,
  input  logic [NUM_CH-1:0]        s_in_sync,
  output logic [WIDTH-1:0]         s_out,
  output logic                     s_out_valid,
  output logic [CHW-1:0]           s_out_ch,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  typedef enum logic {SECTION_A, SECTION_B} section_t;

  section_t         section;
  logic [WIDTH-1:0] val;
  logic [CHW-1:0]   rr_ptr;
  logic [CHW-1:0]   grant;

  logic             any_sync;
  logic             found;
  logic [CHW-1:0]   cand;
  logic [CHW-1:0]   grant_nx;
  logic [CHW-1:0]   ptr_nx;
  logic [WIDTH-1:0] data_sel;
  logic [WIDTH:0]   acc;
  logic [16:0]      pop;
  logic [16:0]      drop_inc;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_next;

  always_comb begin
    any_sync = |s_in_sync;
    found    = 1'b0;
    cand     = '0;
    grant_nx = '0;
    // Scan offsets from rr_ptr so the first hit is the round-robin winner.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CHW'((32'(rr_ptr) + i) % NUM_CH);
      if (!found && s_in_sync[cand]) begin
        found    = 1'b1;
        grant_nx = cand;
      end
    end
    ptr_nx   = CHW'((32'(grant_nx) + 1) % NUM_CH);
    data_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CHW'(i) == grant_nx) data_sel = s_in[i*WIDTH +: WIDTH];
    end
    acc = {1'b0, val} + {1'b0, data_sel};

    pop = 17'($countones(s_in_sync));
    if (section == SECTION_A) drop_inc = any_sync ? pop - 17'd1 : '0;
    else                      drop_inc = pop;
    drop_sum  = {1'b0, drop_cnt} + drop_inc;
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      section     <= SECTION_A;
      val         <= WIDTH'(RESET_VAL);
      s_out       <= WIDTH'(RESET_VAL);
      s_out_valid <= 1'b0;
      s_out_ch    <= '0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
    end else begin
      s_out_valid <= 1'b0;
      drop_cnt    <= drop_next;
      case (section)
        SECTION_A: begin
          if (any_sync) begin
            grant   <= grant_nx;
            rr_ptr  <= ptr_nx;
            val     <= (MODE != 0) ? acc[WIDTH-1:0] : data_sel;
            if (MODE != 0 && acc[WIDTH]) overflow <= 1'b1;
            section <= SECTION_B;
          end
        end
        SECTION_B: begin
          s_out       <= val;
          s_out_ch    <= grant;
          s_out_valid <= 1'b1;
          section     <= SECTION_A;
        end
        default: section <= SECTION_A;
      endcase
    end
  end

endmodule
